// File: rtl/dmem_pkg.sv
// Shared encodings for the byte-lane data memory.
// Pure declarations, no logic and no latency.
// No flow control lives here.
package dmem_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_IDLE  = 1'b1
  } state_e;

  // Width of the word index for a memory of 'depth' 32-bit words.
  function automatic int dmem_idx_w(input int depth);
    return $clog2(depth);
  endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Byte-lane steering: store lane mask/replication, load extraction and extension.
// Purely combinational, zero latency.
// No flow control; the caller qualifies every output with its own accept.
module dmem_lane_align
  import dmem_pkg::*;
(
  input  logic [1:0]  size,
  input  logic        is_unsigned,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] wdata,
  input  logic [31:0] rword,
  output logic [3:0]  lane_mask,
  output logic [31:0] wdata_lanes,
  output logic [31:0] rdata_ext,
  output logic        misalign
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Pick the addressed lanes, replicate store data and extend load data by size.
  always_comb begin
    lane_mask   = 4'b0000;
    wdata_lanes = 32'h0;
    rdata_ext   = 32'h0;
    misalign    = 1'b0;
    byte_sel    = rword[{addr_lo, 3'b000} +: 8];
    half_sel    = addr_lo[1] ? rword[31:16] : rword[15:0];
    case (size)
      SZ_BYTE: begin
        lane_mask   = 4'b0001 << addr_lo;
        wdata_lanes = {4{wdata[7:0]}};
        rdata_ext   = {{24{~is_unsigned & byte_sel[7]}}, byte_sel};
      end
      SZ_HALF: begin
        misalign    = addr_lo[0];
        lane_mask   = addr_lo[1] ? 4'b1100 : 4'b0011;
        wdata_lanes = {2{wdata[15:0]}};
        rdata_ext   = {{16{~is_unsigned & half_sel[15]}}, half_sel};
      end
      SZ_WORD: begin
        misalign    = (addr_lo != 2'b00);
        lane_mask   = 4'b1111;
        wdata_lanes = wdata;
        rdata_ext   = rword;
      end
      default: begin
        // Illegal size: no lanes touched, error raised by the top level.
      end
    endcase
  end

endmodule

// File: rtl/data_mem_bytelane.sv
// Byte-addressed data memory with byte/half/word access and post-reset clear sweep.
// Response registered one cycle after accept; clear sweep takes DEPTH cycles.
// req_ready low while clearing; in IDLE a request is accepted every cycle.
module data_mem_bytelane
  import dmem_pkg::*;
#(
  parameter int DEPTH          = 1024,
  parameter int ADDR_W         = 32,
  parameter bit CLEAR_ON_RESET = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err,
  output logic              busy
);

  localparam int IDX_W = dmem_idx_w(DEPTH);

  logic [31:0] mem [DEPTH];

  state_e          state_q, state_d;
  logic [IDX_W-1:0] clr_idx_q, clr_idx_d;
  logic            rsp_valid_q, rsp_valid_d;
  logic [31:0]     rsp_rdata_q, rsp_rdata_d;
  logic            rsp_err_q, rsp_err_d;

  logic [IDX_W-1:0] word_idx;
  logic [31:0]     rword;
  logic [3:0]      lane_mask;
  logic [31:0]     wdata_lanes;
  logic [31:0]     rdata_ext;
  logic            misalign;
  logic            out_of_range;
  logic            req_err;
  logic            accept;
  logic            clr_we;
  logic            st_we;

  assign word_idx = req_addr[IDX_W+1:2];
  assign rword    = mem[word_idx];

  dmem_lane_align u_align (
    .size        (req_size),
    .is_unsigned (req_unsigned),
    .addr_lo     (req_addr[1:0]),
    .wdata       (req_wdata),
    .rword       (rword),
    .lane_mask   (lane_mask),
    .wdata_lanes (wdata_lanes),
    .rdata_ext   (rdata_ext),
    .misalign    (misalign)
  );

  // Decode accept, error and write enables; writes are suppressed while reset is held.
  always_comb begin
    req_ready    = (state_q == ST_IDLE);
    busy         = (state_q == ST_CLEAR);
    accept       = req_valid && req_ready;
    out_of_range = ((req_addr >> (IDX_W + 2)) != '0);
    req_err      = misalign || (req_size == 2'b11) || out_of_range;
    clr_we       = (state_q == ST_CLEAR) && !reset;
    st_we        = accept && req_write && !req_err && !reset;
  end

  // Clear sweep walks every word once, then hands over to IDLE.
  always_comb begin
    state_d   = state_q;
    clr_idx_d = clr_idx_q;
    if (state_q == ST_CLEAR) begin
      clr_idx_d = clr_idx_q + 1'b1;
      if (clr_idx_q == IDX_W'(DEPTH - 1)) begin
        state_d = ST_IDLE;
      end
    end
  end

  // Next response: strobe per accept, data only for good loads, error otherwise.
  always_comb begin
    rsp_valid_d = accept;
    rsp_err_d   = accept && req_err;
    rsp_rdata_d = 32'h0;
    if (accept && !req_write && !req_err) begin
      rsp_rdata_d = rdata_ext;
    end
  end

  // FSM, sweep counter and response registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= CLEAR_ON_RESET ? ST_CLEAR : ST_IDLE;
      clr_idx_q   <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= 32'h0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      clr_idx_q   <= clr_idx_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  // Storage: sweep clears whole words, stores update only their lanes.
  always_ff @(posedge clk) begin
    if (clr_we) begin
      mem[clr_idx_q] <= 32'h0;
    end else if (st_we) begin
      for (int k = 0; k < 4; k++) begin
        if (lane_mask[k]) begin
          mem[word_idx][8*k +: 8] <= wdata_lanes[8*k +: 8];
        end
      end
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_data_mem_bytelane.sv
// Self-checking bench for data_mem_bytelane (DEPTH = 16, clear on reset).
module tb_data_mem_bytelane;

  localparam int DEPTH = 16;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        busy;

  int n_checks = 0;
  int n_fail   = 0;

  data_mem_bytelane #(.DEPTH(DEPTH), .ADDR_W(32), .CLEAR_ON_RESET(1'b1)) dut (
    .clk          (clk),
    .reset        (reset),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_write    (req_write),
    .req_size     (req_size),
    .req_unsigned (req_unsigned),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .rsp_valid    (rsp_valid),
    .rsp_rdata    (rsp_rdata),
    .rsp_err      (rsp_err),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  // ---------------- behavioural reference model ----------------
  logic [31:0] m_mem [DEPTH];
  int          m_cnt;          // rising edges seen since reset release
  logic        m_vld;
  logic [31:0] m_rdata;
  logic        m_err;

  function automatic bit m_is_err(input logic [31:0] addr, input logic [1:0] size);
    if (size == 2'd3) return 1'b1;
    if ((addr % (32'd1 << size)) != 0) return 1'b1;
    if (addr >= 4 * DEPTH) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [31:0] m_load(input logic [31:0] addr, input logic [1:0] size,
                                         input logic uns);
    logic [31:0] w, v;
    w = m_mem[(addr / 4) % DEPTH];
    v = w;
    if (size == 2'd0) begin
      v = (w >> (8 * (addr % 4))) & 32'hFF;
      if (!uns && v >= 32'h80) v = v + 32'hFFFFFF00;
    end else if (size == 2'd1) begin
      v = (w >> (16 * ((addr / 2) % 2))) & 32'hFFFF;
      if (!uns && v >= 32'h8000) v = v + 32'hFFFF0000;
    end
    return v;
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_cnt = 0; m_vld = 1'b0; m_rdata = 32'h0; m_err = 1'b0;
      for (int i = 0; i < DEPTH; i++) m_mem[i] = 32'h0;
    end else begin
      m_vld = 1'b0; m_rdata = 32'h0; m_err = 1'b0;
      if (req_valid && m_cnt >= DEPTH) begin
        m_vld = 1'b1;
        if (m_is_err(req_addr, req_size)) begin
          m_err = 1'b1;
        end else if (req_write) begin
          for (int b = 0; b < (1 << req_size); b++) begin
            int lane;
            lane = int'(req_addr % 4) + b;
            m_mem[(req_addr / 4) % DEPTH][8*lane +: 8] = req_wdata[8*b +: 8];
          end
        end else begin
          m_rdata = m_load(req_addr, req_size, req_unsigned);
        end
      end
      if (m_cnt < DEPTH) m_cnt = m_cnt + 1;
    end
  end

  // ---------------- checking helpers ----------------
  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h at %0t", name, got, exp, $time);
    end
  endtask

  // Every negedge: outputs against the model.
  task automatic compare();
    chk("req_ready", 32'(req_ready), 32'(m_cnt >= DEPTH));
    chk("busy", 32'(busy), 32'(m_cnt < DEPTH));
    chk("rsp_valid", 32'(rsp_valid), 32'(m_vld));
    if (m_vld) begin
      chk("rsp_rdata", rsp_rdata, m_rdata);
      chk("rsp_err", 32'(rsp_err), 32'(m_err));
    end
  endtask

  task automatic cycle();
    @(negedge clk);
    compare();
  endtask

  task automatic set_req(input logic wr, input logic [1:0] sz, input logic uns,
                         input logic [31:0] addr, input logic [31:0] wd);
    req_valid = 1'b1; req_write = wr; req_size = sz; req_unsigned = uns;
    req_addr = addr; req_wdata = wd;
  endtask

  task automatic idle_req();
    req_valid = 1'b0; req_write = 1'b0; req_size = 2'd2; req_unsigned = 1'b0;
    req_addr = 32'h0; req_wdata = 32'h0;
  endtask

  // One request then its response cycle; returns the response for literal pins.
  task automatic xfer(input logic wr, input logic [1:0] sz, input logic uns,
                      input logic [31:0] addr, input logic [31:0] wd,
                      output logic [31:0] rd, output logic er);
    set_req(wr, sz, uns, addr, wd);
    cycle();
    rd = rsp_rdata;
    er = rsp_err;
  endtask

  logic [31:0] rd;
  logic        er;

  initial begin
    reset = 1'b1;
    idle_req();
    repeat (2) @(negedge clk);
    chk("reset_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("reset_rsp_rdata", rsp_rdata, 32'd0);
    chk("reset_busy", 32'(busy), 32'd1);
    chk("reset_ready", 32'(req_ready), 32'd0);
    reset = 1'b0;

    // Sweep: random requests while busy must be ignored.
    for (int i = 0; i < DEPTH; i++) begin
      set_req(1'b1, 2'd2, 1'b0, 32'($urandom_range(0, 63)) & 32'hFFFF_FFFC, $urandom);
      req_valid = 1'($urandom);
      cycle();
      chk("sweep_ready", 32'(req_ready), 32'(i == DEPTH - 1));
    end

    for (int i = 0; i < DEPTH; i++) begin
      xfer(1'b0, 2'd2, 1'b0, 32'(4 * i), 32'h0, rd, er);
      chk("cleared_word", rd, 32'h0);
    end

    xfer(1'b1, 2'd2, 1'b0, 32'h8, 32'h11223344, rd, er);
    chk("sw_err", 32'(er), 32'd0);
    xfer(1'b1, 2'd0, 1'b0, 32'h9, 32'h000000AA, rd, er);
    xfer(1'b0, 2'd2, 1'b0, 32'h8, 32'h0, rd, er);
    chk("lw_after_sb", rd, 32'h1122AA44);

    xfer(1'b1, 2'd2, 1'b0, 32'h0, 32'h8000FF80, rd, er);
    xfer(1'b0, 2'd0, 1'b0, 32'h0, 32'h0, rd, er);
    chk("lb", rd, 32'hFFFFFF80);
    xfer(1'b0, 2'd0, 1'b1, 32'h0, 32'h0, rd, er);
    chk("lbu", rd, 32'h00000080);
    xfer(1'b0, 2'd1, 1'b0, 32'h2, 32'h0, rd, er);
    chk("lh", rd, 32'hFFFF8000);
    xfer(1'b0, 2'd1, 1'b1, 32'h2, 32'h0, rd, er);
    chk("lhu", rd, 32'h00008000);

    xfer(1'b0, 2'd2, 1'b0, 32'h6, 32'h0, rd, er);
    chk("lw_misalign_err", 32'(er), 32'd1);
    chk("lw_misalign_data", rd, 32'h0);
    xfer(1'b1, 2'd1, 1'b0, 32'h3, 32'h0000FFFF, rd, er);
    chk("sh_misalign_err", 32'(er), 32'd1);
    xfer(1'b1, 2'd2, 1'b0, 32'(DEPTH * 4), 32'hFFFFFFFF, rd, er);
    chk("oor_err", 32'(er), 32'd1);
    xfer(1'b0, 2'd2, 1'b0, 32'h0, 32'h0, rd, er);
    chk("unchanged_after_err", rd, 32'h8000FF80);

    xfer(1'b1, 2'd2, 1'b0, 32'h4, 32'hDEADBEEF, rd, er);
    xfer(1'b0, 2'd2, 1'b0, 32'h4, 32'h0, rd, er);
    chk("store_then_load", rd, 32'hDEADBEEF);

    // Randomized traffic, checked against the model every cycle.
    for (int i = 0; i < 400; i++) begin
      logic [31:0] a;
      a = ($urandom_range(0, 7) == 0) ? $urandom : 32'($urandom_range(0, 4 * DEPTH + 7));
      set_req(1'($urandom), 2'($urandom_range(0, 3)), 1'($urandom), a, $urandom);
      req_valid = ($urandom_range(0, 3) != 0);
      cycle();
    end

    // Reset while a response is pending.
    set_req(1'b0, 2'd2, 1'b0, 32'h4, 32'h0);
    @(posedge clk);
    #2 reset = 1'b1;
    #1 chk("reset_mid_req_rsp_valid", 32'(rsp_valid), 32'd0);
    idle_req();
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 5; i++) cycle();
    // Now in sweep cycle 5.
    #1 reset = 1'b1;
    #1 chk("reset_mid_sweep_busy", 32'(busy), 32'd1);
    chk("reset_mid_sweep_rsp_valid", 32'(rsp_valid), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      cycle();
      chk("resweep_ready", 32'(req_ready), 32'(i == DEPTH - 1));
    end
    xfer(1'b0, 2'd2, 1'b0, 32'h4, 32'h0, rd, er);
    chk("resweep_cleared", rd, 32'h0);
    idle_req();
    cycle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/data_mem_bytelane.md
# data_mem_bytelane

Parametrised data memory for the MIPS datapath, replacing the fixed 1024-word, word-only store. Takes byte addresses and supports byte, halfword and word loads and stores, with sign or zero extension on loads. Detects misaligned and out-of-range accesses. Clears its contents with a sequential sweep after reset, and uses a valid/ready request port with a registered one-cycle response. It sits in the MEM stage between the ALU result/rt path and the write-back mux.

## Interface
- DEPTH, 1024: number of 32-bit words; must be a power of two, at least 2.
- ADDR_W, 32: width of the byte address.
- CLEAR_ON_RESET, 1: 1 = sweep-clear all words after reset; 0 = contents undefined after reset, ready immediately.

- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  block can accept a request this cycle.
- req_write  in  1  1 = store, 0 = load.
- req_size  in  2  00 byte, 01 half, 10 word, 11 illegal.
- req_unsigned  in  1  load zero-extends (lbu/lhu); ignored for word loads and for stores.
- req_addr  in  ADDR_W  byte address.
- req_wdata  in  32  store data, right-aligned (byte in [7:0], half in [15:0]).
- rsp_valid  out  1  response strobe, one cycle per accepted request.
- rsp_rdata  out  32  extended load data; 0 for stores and errors.
- rsp_err  out  1  misaligned, out-of-range or illegal-size request.
- busy  out  1  clear sweep in progress.

## Operation
- FSM states:
  - CLEAR: writes 0 to word clr_idx and increments it each cycle. Moves to IDLE after word DEPTH-1 is written.
  - IDLE: accepts requests.
- req_ready = (state == IDLE). busy = (state == CLEAR).
- A request is accepted when req_valid && req_ready.
- Word index = req_addr[log2(DEPTH)+1:2]. Endianness is little-endian: byte lane k holds bits [8k+7:8k].
- Error conditions:
  - Half access with addr[0] = 1.
  - Word access with addr[1:0] != 0.
  - req_size = 11.
  - Any of req_addr[ADDR_W-1:log2(DEPTH)+2] nonzero.
- On error: memory is not modified, rsp_err = 1, rsp_rdata = 0.
- Stores write only the addressed lanes: byte uses 1 lane, half uses 2, word uses 4. The other lanes keep their value.
- Loads:
  - Byte and half results are sign-extended, or zero-extended when req_unsigned = 1.
  - Lane selection uses addr[1:0] for bytes and addr[1] for halves.
  - rsp_err = 0.
- No request is dropped. Back-to-back requests are allowed every cycle in IDLE.

## Timing
- Reset state:
  - state = CLEAR if CLEAR_ON_RESET, else IDLE. clr_idx = 0.
  - rsp_valid = 0, rsp_rdata = 0, rsp_err = 0.
  - busy = CLEAR_ON_RESET. req_ready = !CLEAR_ON_RESET.
- The clear sweep takes exactly DEPTH cycles after reset deasserts. req_ready rises in cycle DEPTH, counted from 0.
- Response latency is 1 cycle: request accepted at edge n gives rsp_valid, rsp_rdata and rsp_err registered at edge n, visible in cycle n+1.
- rsp_valid is high for exactly one cycle per accepted request, and low in cycles with no accept.
- A store commits at its accept edge, so a load of the same address accepted in the next cycle returns the new data.
- Reset asserted mid-sweep or mid-request: the pending response is discarded, outputs go to reset values immediately, and the sweep restarts from 0.
- req_valid while busy is ignored. The requester must hold the request until it sees req_ready.

## Structure
- Package dmem_pkg:
  - Size encodings SZ_BYTE, SZ_HALF, SZ_WORD.
  - State enum {ST_CLEAR, ST_IDLE}.
  - Function clog2-based index width.
- Sub-module dmem_lane_align (combinational):
  - Store side: lane mask generation and replication of write data into lanes.
  - Load side: lane extraction and sign/zero extension.
  - Misalignment flag.
- The top level holds the storage array, the FSM, the clear counter and the response registers.

## Test plan
- Reset with CLEAR_ON_RESET = 1, DEPTH = 16 -> busy high for 16 cycles, req_ready rises in cycle 16. Every word then reads 0x00000000.
- Word store 0x11223344 @0x8, then byte store 0xAA @0x9, then word load @0x8 -> 0x1122AA44. Each response is one cycle after its accept, with rsp_err = 0.
- After 0x8000FF80 is stored @0x0:
  - lb @0x0 -> 0xFFFFFF80; lbu @0x0 -> 0x00000080.
  - lh @0x2 -> 0xFFFF8000; lhu @0x2 -> 0x00008000.
- lw @0x6 and sh @0x3 -> rsp_err = 1, rsp_rdata = 0, memory unchanged. An access @(DEPTH*4) -> rsp_err = 1.
- Store 0xDEADBEEF @0x4 at cycle n and lw @0x4 at cycle n+1 -> the load returns 0xDEADBEEF at cycle n+2.
- Assert reset at sweep cycle 5 -> rsp_valid = 0 immediately, and the sweep restarts and takes a full DEPTH cycles after release.
